mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single-ported RAM between the instruction fetch path (iREN) and the data path (dREN/dWEN/datomic).
- The data path's memory-control signals come from the control unit.
- Grants one requester at a time, holds the grant until RAM completes, returns data with a one-cycle wait release, and retries on ERROR.
- Implements LL/SC with a single link register: a LL is a dREN with datomic=1; a SC is a dWEN with datomic=1.

Parameters:
- ADDR_W, 32, address/data width (word_t).
- RETRY_MAX, 3, maximum consecutive ERROR retries of one access before the sticky error flag sets.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset: synchronous, active-high
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request (dREN and dWEN are never both high)
- datomic  in  1  qualifies dREN as LL and dWEN as SC
- daddr  in  32  data address
- dstore  in  32  data store value
- iwait  out  1  high = instruction request not complete
- dwait  out  1  high = data request not complete
- iload  out  32  instruction read data
- dload  out  32  data read data; SC result (1 = success, 0 = fail)
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_err  out  1  sticky: an access exhausted RETRY_MAX retries

Behaviour:
- States: IDLE, GNT_D, GNT_I, SC_FAIL. State, retry counter, link register (addr + valid) and mem_err are all registered.
- Reset (RST high at a CLK edge) sets:
  - state=IDLE, link valid=0, retry=0, mem_err=0.
  - Reset mid-access abandons the access; RAM enables drop the next cycle.
- Outputs in IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0; iwait=iREN, dwait=(dREN|dWEN); iload=dload=0.
- IDLE transitions:
  - dREN|dWEN pending → GNT_D. Data has fixed priority over instruction.
  - SC pending with link invalid or link addr≠daddr → SC_FAIL instead.
  - Otherwise iREN → GNT_I.
  - Otherwise stay in IDLE.
- GNT_D:
  - Drives ramaddr=daddr, ramREN=dREN, ramWEN=dWEN, ramstore=dstore.
  - On ramstate==ACCESS (same cycle, combinational):
    - dwait=0; dload=ramload for reads, dload=1 for a successful SC.
    - Next state IDLE; retry cleared.
- GNT_I:
  - Drives ramaddr=iaddr, ramREN=1.
  - On ACCESS: iwait=0, iload=ramload, next state IDLE.
  - iwait stays 1 while any access is not complete.
- ramstate BUSY or FREE while granted: hold the state; wait outputs stay 1.
- ramstate ERROR while granted:
  - retry<RETRY_MAX: retry+1, stay in the state (request reissued).
  - retry==RETRY_MAX: set mem_err, release wait as on ACCESS with load data 0, go to IDLE, clear retry.
- SC_FAIL:
  - No RAM enables.
  - dwait=0, dload=0 for one cycle, then IDLE.
  - Latency: 1 cycle after the IDLE cycle.
- Link register:
  - LL completion sets valid=1, addr=daddr.
  - Any successful SC clears valid.
  - Any plain dWEN completing to the linked addr clears valid.
  - Plain dWEN to another addr leaves the link unchanged.
- Minimum latency: request seen in IDLE at cycle N; grant at N+1; wait low in the first granted cycle with ramstate==ACCESS (earliest N+1).
- Requesters change or drop a request in the cycle its wait is low. A request still asserted in the following IDLE cycle is treated as new.
- Back-to-back: IDLE is mandatory between grants (one turnaround cycle).
- Simultaneous iREN and dREN in IDLE: data is granted. The instruction request is granted after the data completes and the IDLE cycle elapses.
- Request deasserted while granted: not permitted; the grant is held regardless.

Test Plan:
- Reset, then iREN=1, iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 → iwait low exactly in the ACCESS cycle, iload=0x8C220004; ramREN=1 and ramaddr=0x40 throughout the grant.
- iREN and dREN (daddr=0x100) asserted in the same cycle → ramaddr=0x100 granted first; after dwait drops and one IDLE cycle, ramaddr=0x40 with ramREN=1.
- LL 0x200, then SC 0x200 with dstore=0xAB → one RAM write with ramWEN=1 and ramstore=0xAB; dload=1. A second SC 0x200 → no ramWEN; dload=0 with dwait low one cycle after IDLE.
- LL 0x200, then plain dWEN 0x200, then SC 0x200 → SC fails (dload=0, no RAM write). Repeating with the plain write to 0x204 → SC succeeds.
- ramstate=ERROR for 4 consecutive cycles on a read (RETRY_MAX=3) → mem_err=1; dwait low with dload=0; mem_err stays 1 until RST.
- RST asserted while in GNT_D with BUSY → next cycle state IDLE, ramREN=ramWEN=0, link valid=0, mem_err=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch/data request buses and the single RAM port served by mem_arbiter.
// The slave modport is the arbiter's view; master is the CPU-plus-RAM environment.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              dREN;
   logic              dWEN;
   logic              datomic;
   logic [ADDR_W-1:0] daddr;
   logic [ADDR_W-1:0] dstore;
   logic              iwait;
   logic              dwait;
   logic [ADDR_W-1:0] iload;
   logic [ADDR_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [ADDR_W-1:0] ramstore;
   logic [ADDR_W-1:0] ramload;
   logic [1:0]        ramstate;
   logic              mem_err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data path has priority over instruction fetch, ERROR retries
// with a sticky failure flag, and LL/SC tracked by one link register.
module mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int RETRY_MAX = 3
) (
   input  logic         CLK,
   input  logic         RST,
   mem_arbiter_if.slave bus
);
   localparam int RETRY_W = $clog2(RETRY_MAX + 1);

   typedef logic [ADDR_W-1:0] word_t;
   typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, SC_FAIL} state_e;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   state_e             state_q, state_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               link_valid_q, link_valid_d;
   word_t              link_addr_q, link_addr_d;
   logic               mem_err_q, mem_err_d;

   logic  iwait_c, dwait_c, ram_ren_c, ram_wen_c;
   word_t iload_c, dload_c, ram_addr_c, ram_store_c;
   logic  is_sc, link_hit, retry_done;

   assign is_sc      = bus.dWEN & bus.datomic;
   assign link_hit   = link_valid_q && (link_addr_q == bus.daddr);
   assign retry_done = (retry_q == RETRY_W'(RETRY_MAX));

   always_comb begin
      state_d      = state_q;
      retry_d      = retry_q;
      link_valid_d = link_valid_q;
      link_addr_d  = link_addr_q;
      mem_err_d    = mem_err_q;
      iwait_c      = bus.iREN;
      dwait_c      = bus.dREN | bus.dWEN;
      iload_c      = '0;
      dload_c      = '0;
      ram_ren_c    = 1'b0;
      ram_wen_c    = 1'b0;
      ram_addr_c   = '0;
      ram_store_c  = '0;

      unique case (state_q)
         IDLE: begin
            if (bus.dREN | bus.dWEN) begin
               // An SC that cannot succeed never touches the RAM.
               state_d = (is_sc && !link_hit) ? SC_FAIL : GNT_D;
            end else if (bus.iREN) begin
               state_d = GNT_I;
            end
         end

         GNT_D: begin
            ram_addr_c  = bus.daddr;
            ram_ren_c   = bus.dREN;
            ram_wen_c   = bus.dWEN;
            ram_store_c = bus.dstore;
            if (bus.ramstate == RS_ACCESS) begin
               dwait_c = 1'b0;
               if (bus.dREN) begin
                  dload_c = bus.ramload;
               end else if (is_sc) begin
                  dload_c = word_t'(1);
               end
               if (bus.dREN && bus.datomic) begin
                  link_valid_d = 1'b1;
                  link_addr_d  = bus.daddr;
               end else if (is_sc || (bus.dWEN && link_hit)) begin
                  link_valid_d = 1'b0;
               end
               state_d = IDLE;
               retry_d = '0;
            end else if (bus.ramstate == RS_ERROR) begin
               if (retry_done) begin
                  dwait_c   = 1'b0;
                  mem_err_d = 1'b1;
                  state_d   = IDLE;
                  retry_d   = '0;
               end else begin
                  retry_d = retry_q + RETRY_W'(1);
               end
            end
         end

         GNT_I: begin
            ram_addr_c = bus.iaddr;
            ram_ren_c  = 1'b1;
            if (bus.ramstate == RS_ACCESS) begin
               iwait_c = 1'b0;
               iload_c = bus.ramload;
               state_d = IDLE;
               retry_d = '0;
            end else if (bus.ramstate == RS_ERROR) begin
               if (retry_done) begin
                  iwait_c   = 1'b0;
                  mem_err_d = 1'b1;
                  state_d   = IDLE;
                  retry_d   = '0;
               end else begin
                  retry_d = retry_q + RETRY_W'(1);
               end
            end
         end

         SC_FAIL: begin
            dwait_c = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         retry_q      <= '0;
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         retry_q      <= retry_d;
         link_valid_q <= link_valid_d;
         link_addr_q  <= link_addr_d;
         mem_err_q    <= mem_err_d;
      end
   end

   assign bus.iwait    = iwait_c;
   assign bus.dwait    = dwait_c;
   assign bus.iload    = iload_c;
   assign bus.dload    = dload_c;
   assign bus.ramREN   = ram_ren_c;
   assign bus.ramWEN   = ram_wen_c;
   assign bus.ramaddr  = ram_addr_c;
   assign bus.ramstore = ram_store_c;
   assign bus.mem_err  = mem_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed LL/SC, priority, retry and reset scenarios, then random
// transactions checked against a transaction-level model (memory array, link, sticky error).
module tb_mem_arbiter;
   localparam int RETRY_MAX = 3;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   typedef enum int {K_I, K_RD, K_WR, K_LL, K_SC} kind_e;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_arbiter_if #(.ADDR_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .RETRY_MAX(RETRY_MAX)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_ramwr = 0;

   logic [31:0] mem [logic [31:0]];
   bit          m_lv;
   logic [31:0] m_la;
   bit          m_err;

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a ^ 32'h5A5A_0000) + 32'h0000_0001;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_req();
      bus.iREN = 1'b0; bus.iaddr = 32'h0;
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.datomic = 1'b0;
      bus.daddr = 32'h0; bus.dstore = 32'h0;
   endtask

   task automatic set_req(input kind_e k, input logic [31:0] a, input logic [31:0] st);
      idle_req();
      bus.iREN    = (k == K_I);
      bus.iaddr   = (k == K_I) ? a : 32'h0;
      bus.dREN    = (k == K_RD) || (k == K_LL);
      bus.dWEN    = (k == K_WR) || (k == K_SC);
      bus.datomic = (k == K_LL) || (k == K_SC);
      bus.daddr   = (k == K_I) ? 32'h0 : a;
      bus.dstore  = st;
   endtask

   // Runs the granted phase; entered and left just after a falling edge.
   task automatic grant(input bit is_d, input int nbusy, input int nerr,
                        input logic exp_ren, input logic exp_wen, input logic [31:0] exp_addr,
                        input bit chk_load, input logic [31:0] exp_load, output bit exhausted);
      int  cyc;
      int  exp_cyc;
      bit  done;
      logic w;
      exhausted = (nerr > RETRY_MAX);
      exp_cyc   = exhausted ? RETRY_MAX + 1 : nerr + nbusy + 1;
      done      = 1'b0;
      cyc       = 1;
      while (!done && cyc <= 50) begin
         if (cyc <= nerr) bus.ramstate = ERROR;
         else if (cyc <= nerr + nbusy) bus.ramstate = BUSY;
         else bus.ramstate = ACCESS;
         #1;
         bus.ramload = (bus.ramstate == ACCESS && bus.ramREN) ? rd(bus.ramaddr) : $urandom;
         #1;
         chk("grant_bus", 64'({bus.ramREN, bus.ramWEN, bus.ramaddr}),
             64'({exp_ren, exp_wen, exp_addr}));
         if (exp_wen) chk("grant_store", 64'(bus.ramstore), 64'(bus.dstore));
         w = is_d ? bus.dwait : bus.iwait;
         if (!w) begin
            done = 1'b1;
            chk("latency", 64'(cyc), 64'(exp_cyc));
            if (exhausted) chk("err_load", 64'(is_d ? bus.dload : bus.iload), 64'(0));
            else if (chk_load) chk("load", 64'(is_d ? bus.dload : bus.iload), 64'(exp_load));
            if (bus.ramstate == ACCESS && bus.ramWEN) begin
               mem[bus.ramaddr] = bus.ramstore;
               n_ramwr++;
            end
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      if (!done) chk("timeout", 64'(1), 64'(0));
      bus.ramstate = FREE;
   endtask

   task automatic txn(input kind_e k, input logic [31:0] a, input logic [31:0] st,
                      input int nbusy, input int nerr);
      bit          exh;
      bit          scf;
      logic [31:0] el;
      bit          wen;
      set_req(k, a, st);
      bus.ramstate = FREE;
      #1;
      chk("idle_en", 64'({bus.ramREN, bus.ramWEN}), 64'(0));
      chk("idle_wait", 64'(k == K_I ? bus.iwait : bus.dwait), 64'(1));
      chk("mem_err", 64'(bus.mem_err), 64'(m_err));
      @(posedge clk);
      @(negedge clk);
      scf = (k == K_SC) && !(m_lv && m_la == a);
      exh = 1'b0;
      if (scf) begin
         #1;
         chk("scf_en", 64'({bus.ramREN, bus.ramWEN}), 64'(0));
         chk("scf_dwait", 64'(bus.dwait), 64'(0));
         chk("scf_dload", 64'(bus.dload), 64'(0));
         @(posedge clk);
         @(negedge clk);
      end else begin
         wen = (k == K_WR) || (k == K_SC);
         el  = (k == K_SC) ? 32'd1 : rd(a);
         grant(k != K_I, nbusy, nerr, !wen, wen, a, k != K_WR, el, exh);
         if (exh) m_err = 1'b1;
         else if (k == K_LL) begin m_lv = 1'b1; m_la = a; end
         else if (k == K_SC) m_lv = 1'b0;
         else if (k == K_WR && m_la == a) m_lv = 1'b0;
      end
      $display("txn %s addr=%08h store=%08h busy=%0d err=%0d scfail=%0d exhausted=%0d",
               k.name(), a, st, nbusy, nerr, scf, exh);
   endtask

   initial begin
      bit          exh;
      int          wr0;
      logic [31:0] pool [4];
      pool[0] = 32'h200; pool[1] = 32'h204; pool[2] = 32'h208; pool[3] = 32'h40;

      idle_req();
      bus.ramstate = FREE;
      bus.ramload  = 32'h0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_lv = 1'b0; m_la = 32'h0; m_err = 1'b0;
      #1;
      chk("rst_wait", 64'({bus.iwait, bus.dwait}), 64'(0));
      chk("rst_en", 64'({bus.ramREN, bus.ramWEN, bus.ramaddr}), 64'(0));
      chk("rst_err", 64'(bus.mem_err), 64'(0));

      mem[32'h40] = 32'h8C22_0004;
      txn(K_I, 32'h40, 32'h0, 2, 0);

      // Simultaneous fetch and data read: data first, one turnaround cycle, then fetch.
      idle_req();
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 1'b1; bus.daddr = 32'h100;
      #1;
      chk("both_idle_en", 64'(bus.ramREN), 64'(0));
      @(posedge clk);
      @(negedge clk);
      grant(1'b1, 1, 0, 1'b1, 1'b0, 32'h100, 1'b1, rd(32'h100), exh);
      bus.dREN = 1'b0;
      #1;
      chk("turn_en", 64'(bus.ramREN), 64'(0));
      chk("turn_iwait", 64'(bus.iwait), 64'(1));
      @(posedge clk);
      @(negedge clk);
      grant(1'b0, 0, 0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h8C22_0004, exh);
      $display("txn BOTH daddr=00000100 then iaddr=00000040");

      txn(K_LL, 32'h200, 32'h0, 1, 0);
      wr0 = n_ramwr;
      txn(K_SC, 32'h200, 32'hAB, 1, 0);
      chk("sc_writes", 64'(n_ramwr - wr0), 64'(1));
      chk("sc_mem", 64'(rd(32'h200)), 64'(32'hAB));
      wr0 = n_ramwr;
      txn(K_SC, 32'h200, 32'hCD, 0, 0);
      chk("sc2_writes", 64'(n_ramwr - wr0), 64'(0));

      txn(K_LL, 32'h200, 32'h0, 0, 0);
      txn(K_WR, 32'h200, 32'h11, 0, 0);
      wr0 = n_ramwr;
      txn(K_SC, 32'h200, 32'h22, 0, 0);
      chk("sc3_writes", 64'(n_ramwr - wr0), 64'(0));
      txn(K_LL, 32'h200, 32'h0, 0, 0);
      txn(K_WR, 32'h204, 32'h33, 0, 0);
      wr0 = n_ramwr;
      txn(K_SC, 32'h200, 32'h44, 0, 0);
      chk("sc4_writes", 64'(n_ramwr - wr0), 64'(1));

      txn(K_RD, 32'h208, 32'h0, 0, 4);
      #1;
      chk("err_sticky", 64'(bus.mem_err), 64'(1));
      txn(K_I, 32'h40, 32'h0, 0, 0);

      // Reset during a busy data grant.
      txn(K_LL, 32'h300, 32'h0, 0, 0);
      set_req(K_RD, 32'h300, 32'h0);
      @(posedge clk);
      @(negedge clk);
      bus.ramstate = BUSY;
      #1;
      chk("pre_rst_en", 64'(bus.ramREN), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.ramstate = FREE;
      m_lv = 1'b0; m_err = 1'b0;
      #1;
      chk("post_rst_en", 64'({bus.ramREN, bus.ramWEN}), 64'(0));
      chk("post_rst_dwait", 64'(bus.dwait), 64'(1));
      chk("post_rst_err", 64'(bus.mem_err), 64'(0));
      @(posedge clk);
      @(negedge clk);
      grant(1'b1, 0, 0, 1'b1, 1'b0, 32'h300, 1'b1, rd(32'h300), exh);
      wr0 = n_ramwr;
      txn(K_SC, 32'h300, 32'h55, 0, 0);
      chk("post_rst_sc", 64'(n_ramwr - wr0), 64'(0));

      for (int i = 0; i < 80; i++) begin
         kind_e k;
         int    nerr;
         k    = kind_e'($urandom_range(0, 4));
         nerr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0;
         txn(k, pool[$urandom_range(0, 3)], $urandom, int'($urandom_range(0, 3)), nerr);
      end

      idle_req();
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
